// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU "c" / loader "l") arbiter and fixed 3-cycle access sequencer for the
// big-endian data memory. Define DMEM_ARB_RR_EN for round-robin; otherwise C has fixed priority over L.
module dmem_arbiter #(
  parameter int MEM_BYTES = 184
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic        c_err,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic        l_err,
  output logic [31:0] l_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_dr,
  output logic        mem_dw,
  output logic [5:0]  mem_state,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [5:0]  STROBE    = 6'b001000;

  state_t      state, state_nxt;
  logic        any_req, grant_l;
  logic        cur_we, cur_bad;
  logic [31:0] cur_addr, cur_wdata;
  logic        sel_l, sel_we, sel_bad;

  assign any_req = c_req | l_req;

`ifdef DMEM_ARB_RR_EN
  // favor_l is set after a C grant so the next tie goes to L, and cleared after an L grant.
  logic favor_l;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         favor_l <= 1'b0;
    else if (state == IDLE && any_req) favor_l <= ~grant_l;
  end
  assign grant_l = l_req & (~c_req | favor_l);
`else
  assign grant_l = l_req & ~c_req;
`endif

  assign cur_we    = grant_l ? l_we    : c_we;
  assign cur_addr  = grant_l ? l_addr  : c_addr;
  assign cur_wdata = grant_l ? l_wdata : c_wdata;
  // Unsigned 32-bit compare against the last word start, so addresses near 2^32 cannot wrap in.
  assign cur_bad   = (cur_addr[1:0] != 2'b00) || (cur_addr > LAST_WORD);

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no branch leaves state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory controls are only non-zero during ACCESS; acks only during RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_ack     <= 1'b0;
      l_ack     <= 1'b0;
      c_err     <= 1'b0;
      l_err     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_dr    <= 1'b0;
      mem_dw    <= 1'b0;
      mem_state <= '0;
      sel_l     <= 1'b0;
      sel_we    <= 1'b0;
      sel_bad   <= 1'b0;
    end else begin
      c_ack     <= 1'b0;
      l_ack     <= 1'b0;
      c_err     <= 1'b0;
      l_err     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_dr    <= 1'b0;
      mem_dw    <= 1'b0;
      mem_state <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_l     <= grant_l;
            sel_we    <= cur_we;
            sel_bad   <= cur_bad;
            mem_addr  <= cur_addr;
            mem_wdata <= cur_wdata;
            mem_dr    <= ~cur_we & ~cur_bad;
            mem_dw    <= cur_we & ~cur_bad;
            mem_state <= cur_bad ? 6'b000000 : STROBE;
          end
        end
        ACCESS: begin
          c_ack <= ~sel_l;
          l_ack <= sel_l;
          c_err <= ~sel_l & sel_bad;
          l_err <= sel_l & sel_bad;
        end
        default: ;
      endcase
    end
  end

  // Read data passes through only for a good read; this hides the memory's undriven bus after writes.
  assign c_rdata = (c_ack && !sel_we && !sel_bad) ? mem_rdata : '0;
  assign l_rdata = (l_ack && !sel_we && !sel_bad) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios against a small big-endian byte memory model.
// Expected arbitration order follows DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;

  localparam logic [5:0] STROBE = 6'b001000;

  logic        CLK, RST;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_ack, c_err, l_ack, l_err;
  logic [31:0] c_rdata, l_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_dr, mem_dw;
  logic [5:0]  mem_state;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MEM_BYTES(184)) dut (
    .CLK(CLK), .RST(RST),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_err(l_err), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dr(mem_dr), .mem_dw(mem_dw),
    .mem_state(mem_state), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: executes at the posedge that ends the strobe cycle; after a write the read bus
  // carries a junk pattern standing in for the real memory's undriven output.
  logic [7:0] mem [0:183];
  initial begin
    for (int i = 0; i < 184; i++) mem[i] = 8'(i);
    mem_rdata = '0;
  end
  always @(posedge CLK) begin
    if (mem_state == STROBE) begin
      if (mem_dw) begin
        mem[mem_addr[7:0]]         <= mem_wdata[31:24];
        mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[23:16];
        mem[mem_addr[7:0] + 8'd2]  <= mem_wdata[15:8];
        mem[mem_addr[7:0] + 8'd3]  <= mem_wdata[7:0];
        mem_rdata <= 32'hBAD0_BAD0;
      end else if (mem_dr) begin
        mem_rdata <= {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                      mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};
      end
    end
  end

  // Results of the most recent issue() call.
  int          r_ack_cyc, r_strobes, r_dw, r_dr, r_wrong_ack;
  logic        r_err;
  logic [31:0] r_rdata, r_saddr, r_swdata;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST   = 1'b1;
    c_req = 1'b0;
    l_req = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  // Raise one request in IDLE, follow it to its ack (cycle 1 = the IDLE sampling cycle), drop req
  // at the ack-sampling edge and leave the arbiter back in IDLE.
  task automatic issue(input bit port_l, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    r_ack_cyc = 0; r_strobes = 0; r_dw = 0; r_dr = 0; r_wrong_ack = 0;
    r_err = 1'b0; r_rdata = '0; r_saddr = '0; r_swdata = '0;
    if (port_l) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    for (int i = 1; i <= 8 && r_ack_cyc == 0; i++) begin
      tick();
      if (mem_state == STROBE) begin
        r_strobes++;
        r_saddr  = mem_addr;
        r_swdata = mem_wdata;
      end
      if (mem_dw) r_dw++;
      if (mem_dr) r_dr++;
      if (port_l ? c_ack : l_ack) r_wrong_ack++;
      if (port_l ? l_ack : c_ack) begin
        r_ack_cyc = i + 1;
        r_err     = port_l ? l_err : c_err;
        r_rdata   = port_l ? l_rdata : c_rdata;
      end
    end
    c_req = 1'b0;
    l_req = 1'b0;
    tick();
    checks++;
    if (r_ack_cyc === 0) begin
      errors++;
      $display("FAIL ack_timeout: port_l=%0d addr=%h got no ack within 8 cycles", port_l, addr);
    end
    checks++;
    if (r_wrong_ack !== 0) begin
      errors++;
      $display("FAIL wrong_port_ack: got %0d acks on other port, expected 0", r_wrong_ack);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    tick();
    tick();
    checks++;
    if ({c_ack, l_ack, c_err, l_err, mem_dr, mem_dw, mem_state} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {c_ack, l_ack, c_err, l_err, mem_dr, mem_dw, mem_state});
    end
    checks++;
    if ({mem_addr, mem_wdata, c_rdata, l_rdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h crd=%h lrd=%h expected 0",
               mem_addr, mem_wdata, c_rdata, l_rdata);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    issue(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (r_ack_cyc !== 3) begin errors++; $display("FAIL lwr_ack_cycle: got %0d expected 3", r_ack_cyc); end
    checks++;
    if (r_err !== 1'b0) begin errors++; $display("FAIL lwr_err: got %b expected 0", r_err); end
    checks++;
    if (r_strobes !== 1 || r_dw !== 1 || r_dr !== 0) begin
      errors++;
      $display("FAIL lwr_strobe: got strobes=%0d dw=%0d dr=%0d expected 1 1 0", r_strobes, r_dw, r_dr);
    end
    checks++;
    if (r_saddr !== 32'h10 || r_swdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lwr_bus: got addr=%h wdata=%h expected 00000010 deadbeef", r_saddr, r_swdata);
    end
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    checks++;
    if (r_ack_cyc !== 3) begin errors++; $display("FAIL crd_ack_cycle: got %0d expected 3", r_ack_cyc); end
    checks++;
    if (r_rdata !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
      errors++;
      $display("FAIL crd_data: got %h err=%b expected deadbeef err=0", r_rdata, r_err);
    end
    checks++;
    if (r_dr !== 1 || r_dw !== 0) begin
      errors++;
      $display("FAIL crd_ctrl: got dr=%0d dw=%0d expected 1 0", r_dr, r_dw);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] addrs  [5] = '{32'h12, 32'hB4, 32'hB5, 32'hB8, 32'hFFFF_FFFC};
    logic        exp_er [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_rd [5] = '{32'h0, 32'hB4B5_B6B7, 32'h0, 32'h0, 32'h0};
    int          exp_st [5] = '{0, 1, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, 1'b0, addrs[k], 32'h0);
      checks++;
      if (r_err !== exp_er[k] || r_rdata !== exp_rd[k]) begin
        errors++;
        $display("FAIL bounds_%h: got err=%b rdata=%h expected err=%b rdata=%h",
                 addrs[k], r_err, r_rdata, exp_er[k], exp_rd[k]);
      end
      checks++;
      if (r_strobes !== exp_st[k] || r_dr !== exp_st[k]) begin
        errors++;
        $display("FAIL bounds_strobe_%h: got strobes=%0d dr=%0d expected %0d",
                 addrs[k], r_strobes, r_dr, exp_st[k]);
      end
    end
  endtask

  task automatic test_write_then_read();
    issue(1'b0, 1'b1, 32'h4, 32'hCAFE_F00D);
    checks++;
    if (r_rdata !== 32'h0 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL cwr_rdata_masked: got rdata=%h err=%b expected 00000000 err=0", r_rdata, r_err);
    end
    issue(1'b0, 1'b0, 32'h4, 32'h0);
    checks++;
    if (r_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL cwr_readback: got %h expected cafef00d", r_rdata);
    end
  endtask

  task automatic test_arbitration();
    logic [12:0] c_pat, l_pat, exp_c, exp_l;
    logic [31:0] c_first, l_first;
    apply_reset();
    c_pat = '0; l_pat = '0; c_first = '0; l_first = '0;
    c_we = 1'b0; c_addr = 32'h0;
    l_we = 1'b0; l_addr = 32'h4;
    c_req = 1'b1;
    l_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      c_pat[i] = c_ack;
      l_pat[i] = l_ack;
      if (c_ack && c_first == 32'h0) c_first = c_rdata;
      if (l_ack && l_first == 32'h0) l_first = l_rdata;
    end
    c_req = 1'b0;
    l_req = 1'b0;
    tick();
    tick();
    tick();
`ifdef DMEM_ARB_RR_EN
    exp_c = 13'h104;
    exp_l = 13'h820;
    checks++;
    if (l_first !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL arb_l_rdata: got %h expected cafef00d", l_first);
    end
`else
    exp_c = 13'h924;
    exp_l = 13'h000;
`endif
    checks++;
    if (c_pat !== exp_c || l_pat !== exp_l) begin
      errors++;
      $display("FAIL arb_order: got c=%b l=%b expected c=%b l=%b", c_pat, l_pat, exp_c, exp_l);
    end
    checks++;
    if (c_first !== 32'h0001_0203) begin
      errors++;
      $display("FAIL arb_c_rdata: got %h expected 00010203", c_first);
    end
  endtask

  task automatic test_reset_mid_access();
    int acks;
    l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h1234_5678;
    l_req = 1'b1;
    tick();
    checks++;
    if (mem_state !== STROBE || mem_dw !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_strobe: got state=%b dw=%b expected 001000 1", mem_state, mem_dw);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({c_ack, l_ack, c_err, l_err, mem_dr, mem_dw, mem_state, mem_addr, mem_wdata, l_rdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got state=%b dw=%b addr=%h wdata=%h lack=%b expected all 0",
               mem_state, mem_dw, mem_addr, mem_wdata, l_ack);
    end
    l_req = 1'b0;
    acks = 0;
    tick();
    if (l_ack || c_ack) acks++;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (l_ack || c_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL mid_reset_no_ack: got %0d acks expected 0", acks); end
    issue(1'b0, 1'b0, 32'h20, 32'h0);
    checks++;
    if (r_rdata !== 32'h2021_2223) begin
      errors++;
      $display("FAIL mid_reset_prior_data: got %h expected 20212223", r_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bounds();
    test_write_then_read();
    test_arbitration();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
